qubit_gate_scheduler: RTL and testbench
=======================================

// Module: qubit_gate_scheduler
// PURPOSE
//  Shares one single-qubit control block between NUM_REQ gate requesters.
//  Round-robin arbitrates queued gate ops (X, H, NOP, WAIT).
//  Drives the control block's one-cycle apply_X_gate / apply_Hadamard_gate strobes.
//  Enforces a post-gate settle window and reports per-op completion.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  SETTLE_CYCLES  3   idle cycles enforced after every X/H strobe (0..15)
//  ARG_W          8   width of WAIT duration argument
//  CNT_W          16  width of issued-gate counter
// PORTS
//  clock          in   1              single clock, rising edge
//  reset          in   1              asynchronous, active-high
//  halt           in   1              block new grants; in-flight op completes
//  req_valid      in   NUM_REQ        requester i has an op pending
//  req_op         in   2*NUM_REQ      op of requester i at [2i+:2]: 00 NOP, 01 X, 10 H, 11 WAIT
//  req_arg        in   ARG_W*NUM_REQ  WAIT cycle count of requester i at [ARG_W*i+:ARG_W]
//  req_ready      out  NUM_REQ        one-hot grant; transfer when valid&ready
//  apply_X_gate   out  1              one-cycle strobe to qubit control block
//  apply_Hadamard_gate out 1          one-cycle strobe to qubit control block
//  busy           out  1              high whenever FSM is not IDLE
//  done_valid     out  1              one-cycle pulse: an accepted op completed
//  done_id        out  $clog2(NUM_REQ) requester index of completed op
//  gate_count     out  CNT_W          number of X/H strobes issued
// BEHAVIOUR
//  Reset (async): state=IDLE, rr pointer so requester 0 wins first.
//   All registered outputs 0; gate_count=0.
//   A strobe in progress drops immediately; the aborted op never reports done.
//  FSM states: IDLE, ISSUE, SETTLE, WAIT.
//  IDLE: req_ready is combinational.
//   = one-hot RR winner among req_valid, when !halt; else all 0.
//   On transfer in cycle T: latch op, arg, id; go to ISSUE.
//   The RR pointer moves to winner+1 (mod NUM_REQ).
//  ISSUE (cycle T+1, exactly one cycle): X op -> apply_X_gate=1; H op -> apply_Hadamard_gate=1.
//   The two strobes are never high together.
//   X/H: gate_count+1, wrapping at 2^CNT_W-1 -> 0.
//   Next state: SETTLE if SETTLE_CYCLES>0, else IDLE.
//   NOP: no strobe, next IDLE.
//   WAIT: no strobe; next WAIT if arg>0, else IDLE.
//  SETTLE: stay SETTLE_CYCLES cycles, then IDLE.
//  WAIT: stay arg cycles, then IDLE.
//  done_valid=1 and done_id=latched id in the first IDLE cycle after the op.
//   That is T+2+SETTLE_CYCLES for X/H, T+2 for NOP and WAIT arg=0, T+2+arg for WAIT.
//   req_ready may grant in that same cycle (back-to-back issue).
//  halt: sampled only in IDLE; mid-op assertion has no effect on the current op.
//  req_ready=0 in every non-IDLE state; requesters hold valid/op/arg until granted.
//  Strobes, busy, done_valid, done_id and gate_count are registered outputs.
//   No combinational input->output path except req_valid/halt -> req_ready.
// STRUCTURE
//  Shared package qgate_pkg holds:
//   - typedef enum logic[1:0] gate_op_e {OP_NOP, OP_X, OP_H, OP_WAIT};
//   - typedef enum sched_state_e {IDLE, ISSUE, SETTLE, WAIT};
//  Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant + index.
//  Settle and wait share one down-counter of width max(ARG_W,4).
// TESTING
//  1. Reset, req0 X alone, SETTLE=3:
//     ready0@T, apply_X@T+1 only, done_valid id=0 @T+5, gate_count=1.
//  2. All 4 requesters valid with H held:
//     grants 0,1,2,3,0 in order; consecutive strobes exactly 5 cycles apart.
//  3. WAIT arg=10 then WAIT arg=0:
//     done @T+12 with no strobe; the arg=0 op completes @T+2.
//  4. halt high with req1 valid:
//     req_ready=0, no strobes; deassert halt -> grant next cycle.
//     halt raised during SETTLE: op still completes with done.
//  5. Async reset asserted the cycle apply_Hadamard_gate is high:
//     strobe falls at once, no done_valid, gate_count=0, next grant to req0.
//  6. gate_count preset path: 65536 X ops (SETTLE=0) -> count wraps to 0.
//     Check apply_X and apply_H are never both high across the run.

Source files
------------

// File: rtl/qgate_pkg.sv
// Shared types for the qubit gate scheduler: gate opcodes, FSM states and a width helper.
package qgate_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_X    = 2'd1,
    OP_H    = 2'd2,
    OP_WAIT = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } sched_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qubit_gate_scheduler_if.sv
// Request bus between NUM_REQ gate requesters and the scheduler.
interface qubit_gate_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ARG_W   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [ARG_W*NUM_REQ-1:0] req_arg;
  logic [NUM_REQ-1:0]       req_ready;

  modport master (output req_valid, req_op, req_arg, input req_ready);
  modport slave  (input req_valid, req_op, req_arg, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, as one-hot grant plus index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int unsigned IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so bit 0 of rot is the requester at ptr.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = IW'((32'(ptr) + k) % N);
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/qubit_gate_scheduler.sv
// Shares one single-qubit control block among NUM_REQ requesters: round-robin grant,
// one-cycle X/H strobes, post-gate settle window and per-op completion report.
module qubit_gate_scheduler
  import qgate_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned ARG_W         = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       halt,
  qubit_gate_scheduler_if.slave      req,
  output logic                       apply_X_gate,
  output logic                       apply_Hadamard_gate,
  output logic                       busy,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]           gate_count
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = max_u(ARG_W, 4);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  sched_state_e     state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    id_q;
  gate_op_e         op_q;
  logic [TW-1:0]    timer;

  logic [NUM_REQ-1:0] win_grant;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               can_grant;
  logic               xfer;
  logic [1:0]         sel_op_bits;
  logic [ARG_W-1:0]   sel_arg;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req.req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  assign can_grant     = (state == IDLE) && !halt;
  assign xfer          = can_grant && win_found;
  assign req.req_ready = can_grant ? win_grant : '0;

  // Payload of the current winner.
  always_comb begin
    sel_op_bits = '0;
    sel_arg     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_op_bits = req.req_op[2*i +: 2];
        sel_arg     = req.req_arg[ARG_W*i +: ARG_W];
      end
    end
  end

  // Settle and wait share the down-counter; it holds remaining cycles minus one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      ptr                 <= '0;
      id_q                <= '0;
      op_q                <= OP_NOP;
      timer               <= '0;
      apply_X_gate        <= 1'b0;
      apply_Hadamard_gate <= 1'b0;
      busy                <= 1'b0;
      done_valid          <= 1'b0;
      done_id             <= '0;
      gate_count          <= '0;
    end else begin
      apply_X_gate        <= 1'b0;
      apply_Hadamard_gate <= 1'b0;
      done_valid          <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            state               <= ISSUE;
            busy                <= 1'b1;
            id_q                <= win_idx;
            op_q                <= gate_op_e'(sel_op_bits);
            timer               <= TW'(sel_arg);
            apply_X_gate        <= (gate_op_e'(sel_op_bits) == OP_X);
            apply_Hadamard_gate <= (gate_op_e'(sel_op_bits) == OP_H);
            ptr                 <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
          end
        end
        ISSUE: begin
          if (op_q == OP_X || op_q == OP_H) begin
            gate_count <= gate_count + CNT_W'(1);
            if (SETTLE_CYCLES > 0) begin
              state <= SETTLE;
              timer <= SETTLE_LAST;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              done_valid <= 1'b1;
              done_id    <= id_q;
            end
          end else if (op_q == OP_WAIT && timer != '0) begin
            state <= WAIT;
            timer <= timer - TW'(1);
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            done_valid <= 1'b1;
            done_id    <= id_q;
          end
        end
        SETTLE, WAIT: begin
          if (timer == '0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done_valid <= 1'b1;
            done_id    <= id_q;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qubit_gate_scheduler.sv
// Scoreboard bench: a timeline model predicts grants, strobes and completions; a monitor checks them.
module tb_qubit_gate_scheduler;
  import qgate_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  typedef struct { int cyc; bit is_h; } strobe_t;
  typedef struct { int cyc; int id; int cnt; } done_t;
  typedef enum int {FILL_NONE, FILL_SAME, FILL_RAND} fill_e;

  logic clock = 1'b0;
  logic reset, halt;
  logic apply_X_gate, apply_Hadamard_gate, busy, done_valid;
  logic [1:0]    done_id;
  logic [CW-1:0] gate_count;

  logic       reset2, halt2;
  logic       ax2, ah2, busy2, dv2;
  logic [0:0] did2;
  logic [3:0] gc2;

  qubit_gate_scheduler_if #(.NUM_REQ(N), .ARG_W(AW)) rq ();
  qubit_gate_scheduler_if #(.NUM_REQ(2), .ARG_W(AW)) rq2 ();

  qubit_gate_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(S), .ARG_W(AW), .CNT_W(CW)) dut (
    .clock               (clock),
    .reset               (reset),
    .halt                (halt),
    .req                 (rq),
    .apply_X_gate        (apply_X_gate),
    .apply_Hadamard_gate (apply_Hadamard_gate),
    .busy                (busy),
    .done_valid          (done_valid),
    .done_id             (done_id),
    .gate_count          (gate_count)
  );

  // Small instance with no settle window and a 4-bit counter to reach the wrap quickly.
  qubit_gate_scheduler #(.NUM_REQ(2), .SETTLE_CYCLES(0), .ARG_W(AW), .CNT_W(4)) dut2 (
    .clock               (clock),
    .reset               (reset2),
    .halt                (halt2),
    .req                 (rq2),
    .apply_X_gate        (ax2),
    .apply_Hadamard_gate (ah2),
    .busy                (busy2),
    .done_valid          (dv2),
    .done_id             (did2),
    .gate_count          (gc2)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int m_free = 0, m_grant = -1, m_ptr = 0, m_count = 0;
  strobe_t  strobe_q[$];
  done_t    done_q[$];
  logic     p_valid [N];
  gate_op_e p_op    [N];
  int       p_arg   [N];
  fill_e    fill = FILL_NONE;
  bit       wrap_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rq.req_valid[i]        = p_valid[i];
      rq.req_op[2*i +: 2]    = p_op[i];
      rq.req_arg[AW*i +: AW] = AW'(p_arg[i]);
    end
  endtask

  task automatic post(input int i, input gate_op_e op, input int arg);
    p_valid[i] = 1'b1;
    p_op[i]    = op;
    p_arg[i]   = arg;
    drive();
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= p_valid[i];
    return r;
  endfunction

  // One clock: predict the grant from the timeline, check ready/busy, then update requesters.
  task automatic step();
    logic [N-1:0] exp_rdy, granted;
    int w, dur;
    @(negedge clock);
    exp_rdy = '0;
    w = -1;
    if (cyc >= m_free && !halt)
      for (int k = 0; k < N; k++)
        if (w < 0 && p_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    check("busy", busy, (cyc > m_grant && cyc < m_free));
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      if (p_op[w] == OP_X || p_op[w] == OP_H) dur = S;
      else if (p_op[w] == OP_WAIT)            dur = p_arg[w];
      else                                    dur = 0;
      if (p_op[w] == OP_X || p_op[w] == OP_H) begin
        m_count = (m_count + 1) % (1 << CW);
        strobe_q.push_back('{cyc + 1, p_op[w] == OP_H});
      end
      done_q.push_back('{cyc + 2 + dur, w, m_count});
      m_grant = cyc;
      m_free  = cyc + 2 + dur;
      m_ptr   = (w + 1) % N;
    end
    check("req_ready", rq.req_ready, exp_rdy);
    granted = rq.req_valid & rq.req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (granted[i]) p_valid[i] = (fill == FILL_SAME);
    if (fill == FILL_RAND) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(3) == 0) begin
          p_valid[i] = 1'b1;
          p_op[i]    = gate_op_e'(2'($urandom_range(3)));
          p_arg[i]   = ($urandom_range(4) == 0) ? int'($urandom_range(40)) : int'($urandom_range(3));
        end
      end
      halt = ($urandom_range(9) == 0);
    end
    drive();
  endtask

  task automatic drain();
    int n = 0;
    fill = FILL_NONE;
    while ((any_pending() || cyc <= m_free) && n < 400) begin
      step();
      n++;
    end
    check("drain_timeout", n < 400, 1);
  endtask

  // Monitor: every strobe and completion must match the head of its expectation queue.
  always @(negedge clock) begin
    strobe_t s;
    done_t   d;
    if (!reset) begin
      check("x_h_exclusive", apply_X_gate & apply_Hadamard_gate, 0);
      while (strobe_q.size() > 0 && strobe_q[0].cyc < cyc) begin
        check("strobe_missing", 0, 1);
        void'(strobe_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        check("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
      if (apply_X_gate || apply_Hadamard_gate) begin
        if (strobe_q.size() == 0) check("strobe_unexpected", 1, 0);
        else begin
          s = strobe_q.pop_front();
          check("strobe_cycle", cyc, s.cyc);
          check("strobe_is_h", apply_Hadamard_gate, s.is_h);
        end
      end
      if (done_valid) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_id", done_id, d.id);
          check("done_gate_count", gate_count, d.cnt);
        end
      end
    end
  end

  // Counter wrap on the small instance: one X op every two cycles.
  initial begin : wrap_proc
    int n;
    reset2 = 1'b1;
    halt2  = 1'b0;
    rq2.req_valid = '0;
    rq2.req_op    = '0;
    rq2.req_arg   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset2 = 1'b0;
    check("wrap_reset_count", gc2, 0);
    rq2.req_valid = 2'b01;
    rq2.req_op    = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      n = 0;
      @(negedge clock);
      while (!dv2 && n < 10) begin
        @(negedge clock);
        n++;
      end
      check("wrap_done_seen", dv2, 1);
      check("wrap_count", gc2, k % 16);
      check("wrap_x_h_exclusive", ax2 & ah2, 0);
    end
    rq2.req_valid = '0;
    wrap_done = 1'b1;
  end

  initial begin : main_proc
    int n;
    reset = 1'b1;
    halt  = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0;
      p_op[i]    = OP_NOP;
      p_arg[i]   = 0;
    end
    drive();
    repeat (3) @(posedge clock);
    #1;
    check("rst_apply_x", apply_X_gate, 0);
    check("rst_apply_h", apply_Hadamard_gate, 0);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_id", done_id, 0);
    check("rst_gate_count", gate_count, 0);
    reset = 1'b0;

    // Lone X on requester 0.
    post(0, OP_X, 0);
    drain();
    check("single_x_count", gate_count, 1);

    // All four hold H: rotation 0,1,2,3,0 with strobes 5 cycles apart.
    for (int i = 0; i < N; i++) post(i, OP_H, 0);
    fill = FILL_SAME;
    repeat (25) step();
    drain();

    // Long WAIT followed by a zero-length WAIT.
    post(2, OP_WAIT, 10);
    drain();
    post(3, OP_WAIT, 0);
    drain();

    // halt blocks grants; raising it mid-settle does not disturb the op.
    halt = 1'b1;
    post(1, OP_X, 0);
    repeat (4) step();
    halt = 1'b0;
    step();
    repeat (2) step();
    halt = 1'b1;
    drain();
    halt = 1'b0;

    // Async reset in the middle of an H strobe.
    post(1, OP_H, 0);
    n = 0;
    while (apply_Hadamard_gate !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("reset_setup_h_high", apply_Hadamard_gate, 1);
    #2 reset = 1'b1;
    #1;
    check("reset_strobe_drop", apply_Hadamard_gate, 0);
    check("reset_gate_count", gate_count, 0);
    check("reset_busy", busy, 0);
    check("reset_no_done", done_valid, 0);
    strobe_q.delete();
    done_q.delete();
    m_free = 0; m_grant = -1; m_ptr = 0; m_count = 0;
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    drive();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) post(i, OP_X, 0);
    #1;
    check("reset_first_grant", rq.req_ready, 4'b0001);
    drain();

    // Randomized traffic with sporadic halt.
    fill = FILL_RAND;
    repeat (2500) step();
    halt = 1'b0;
    drain();

    n = 0;
    while (!wrap_done && n < 1000) begin
      @(posedge clock);
      n++;
    end
    check("wrap_finished", wrap_done, 1);
    check("strobe_queue_empty", strobe_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
